wb_retire_queue: RTL and testbench
==================================

Name: wb_retire_queue

Overview:
- Writeback-side producer for the register/segment file ports of the register-read/address-generation stage.
- Accepts one completed instruction's results per cycle from the execute stage.
- Buffers completed results in an in-order FIFO and drives the shared writeback bus: wb_data1-4, wb_addr1-4, wb_segdata1-4, wb_segaddr1-4, wb_opsize, wb_regld, wb_segld and wb_inst_ptcid.
- Checks that instructions retire in PTC-id order and supports flush and exception retirement.

Parameters:
DEPTH, 2, FIFO entries; power of 2, minimum 2.
PTCW, 7, PTC id width; the counter wraps modulo 2^PTCW.

Ports:
clk  in  1  clock
clr  in  1  synchronous active-low reset
valid_in  in  1  EX result valid; push when valid_in & ready_out
ready_out  out  1  = ~full; registered-state only, no combinational path from valid_in
res_data1..4  in  64 each  register results
res_addr1..4  in  3 each  register destinations
res_regld  in  4  per-slot register load enables
res_segdata1..4  in  16 each  segment results
res_segaddr1..4  in  3 each  segment destinations
res_segld  in  4  per-slot segment load enables
res_opsize  in  2  result size
res_ptcid  in  7  instruction PTC id
res_ie  in  1  instruction raised exception
wb_hold  in  1  suppresses retirement this cycle
flush  in  1  discard all buffered entries
flush_ptcid  in  7  next expected PTC id after flush
wb_data1..4, wb_addr1..4, wb_segdata1..4, wb_segaddr1..4, wb_opsize, wb_inst_ptcid  out  (widths as inputs)  head-entry fields
wb_regld  out  4  head regld masked by wb_valid
wb_segld  out  4  head segld masked by wb_valid
wb_valid  out  1  retire this cycle
wb_exc  out  1  retiring entry carries exception
ptc_order_err  out  1  sticky retire-order violation
count  out  log2(DEPTH)+1  occupancy

Behaviour:
- Reset (clr=0 at posedge): rd_ptr=wr_ptr=0, count=0, expected_ptcid=0, ptc_order_err=0.
  - Resulting outputs: wb_valid=0, wb_regld=0, wb_segld=0, wb_exc=0, ready_out=1.
  - Data outputs present the head entry's stale storage; storage itself is not reset.
  - Reset overrides flush and push.
- Storage: circular buffer indexed by rd_ptr/wr_ptr (log2(DEPTH) bits, natural wrap).
  - full = (count==DEPTH); empty = (count==0).
- Push: on valid_in & ready_out, write all res_* fields at wr_ptr and advance wr_ptr.
  - If res_ie=1, the stored regld and segld are forced to 0; the stored ie bit is 1.
- Retire: wb_valid = ~empty & ~wb_hold.
  - All wb_* data fields come combinationally from the entry at rd_ptr.
  - wb_regld = head.regld & {4{wb_valid}}; wb_segld likewise.
  - wb_exc = wb_valid & head.ie.
  - At posedge with wb_valid=1: pop and advance rd_ptr.
- Latency: a push into an empty queue at edge N is visible with wb_valid=1 in the following cycle (one cycle); there is no bypass.
- Simultaneous push and pop: allowed whenever ready_out=1; count is unchanged.
  - When full, push is refused even if a pop occurs the same cycle.
- Order check:
  - expected_ptcid increments by 1 (mod 2^PTCW) on every pop, exception entries included.
  - If wb_valid & (head.ptcid != expected_ptcid), set ptc_order_err=1. The pop still occurs and expected_ptcid still increments.
  - ptc_order_err clears only on reset.
- Flush (flush=1 at posedge, clr=1):
  - count=0 and rd_ptr=wr_ptr=0.
  - A same-cycle push is discarded; a same-cycle pop does not update expected_ptcid.
  - expected_ptcid=flush_ptcid.
  - wb_valid is still driven combinationally during the flush cycle, so a retire in that cycle does reach the register file.
- Intra-entry duplicate destinations are passed through unchanged; the register file resolves priority.

Test Plan:
- Reset then single push (ptcid=0, res_regld=4'b0001, res_addr1=3, res_data1=64'hDEAD) -> one cycle later wb_valid=1, wb_addr1=3, wb_data1=64'hDEAD, wb_regld=0001; next cycle count=0, wb_valid=0.
- Push ptcids 0,1,2 back-to-back with wb_hold=1 -> ready_out=0 after 2 pushes and the third is refused. Then hold ptcid 2 on valid_in and release wb_hold -> retire order 0,1,2; ptc_order_err=0.
- Streaming push+pop every cycle for 200 instructions (ptcid wraps 127->0) -> count stays at 1, no order error, every wb_data field matches its push.
- Push ptcid=5 after reset (expected 0) -> ptc_order_err=1 on retire, sticky until clr=0.
- Push an entry with res_ie=1, res_regld=1111, res_segld=0010 -> on retire wb_exc=1, wb_regld=0, wb_segld=0, and expected_ptcid increments.
- Queue full, then assert flush with flush_ptcid=40 and a concurrent valid_in -> next cycle count=0, wb_valid=0. A subsequent ptcid 40 retires with no error.

Source files
------------

// File: rtl/wb_retire_queue.sv
// Writeback retire queue: buffers completed EX results in order, drives the
// shared register/segment writeback bus from the head entry and tracks
// PTC-id retire order with a sticky error flag.
module wb_retire_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTCW  = 7
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic [63:0]              res_data1,
    input  logic [63:0]              res_data2,
    input  logic [63:0]              res_data3,
    input  logic [63:0]              res_data4,
    input  logic [2:0]               res_addr1,
    input  logic [2:0]               res_addr2,
    input  logic [2:0]               res_addr3,
    input  logic [2:0]               res_addr4,
    input  logic [3:0]               res_regld,
    input  logic [15:0]              res_segdata1,
    input  logic [15:0]              res_segdata2,
    input  logic [15:0]              res_segdata3,
    input  logic [15:0]              res_segdata4,
    input  logic [2:0]               res_segaddr1,
    input  logic [2:0]               res_segaddr2,
    input  logic [2:0]               res_segaddr3,
    input  logic [2:0]               res_segaddr4,
    input  logic [3:0]               res_segld,
    input  logic [1:0]               res_opsize,
    input  logic [PTCW-1:0]          res_ptcid,
    input  logic                     res_ie,
    input  logic                     wb_hold,
    input  logic                     flush,
    input  logic [PTCW-1:0]          flush_ptcid,
    output logic [63:0]              wb_data1,
    output logic [63:0]              wb_data2,
    output logic [63:0]              wb_data3,
    output logic [63:0]              wb_data4,
    output logic [2:0]               wb_addr1,
    output logic [2:0]               wb_addr2,
    output logic [2:0]               wb_addr3,
    output logic [2:0]               wb_addr4,
    output logic [15:0]              wb_segdata1,
    output logic [15:0]              wb_segdata2,
    output logic [15:0]              wb_segdata3,
    output logic [15:0]              wb_segdata4,
    output logic [2:0]               wb_segaddr1,
    output logic [2:0]               wb_segaddr2,
    output logic [2:0]               wb_segaddr3,
    output logic [2:0]               wb_segaddr4,
    output logic [1:0]               wb_opsize,
    output logic [PTCW-1:0]          wb_inst_ptcid,
    output logic [3:0]               wb_regld,
    output logic [3:0]               wb_segld,
    output logic                     wb_valid,
    output logic                     wb_exc,
    output logic                     ptc_order_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0][63:0] data;
        logic [3:0][2:0]  addr;
        logic [3:0][15:0] segdata;
        logic [3:0][2:0]  segaddr;
        logic [3:0]       regld;
        logic [3:0]       segld;
        logic [1:0]       opsize;
        logic [PTCW-1:0]  ptcid;
        logic             ie;
    } entry_t;

    // Storage is deliberately not reset; only pointers and flags are.
    entry_t          mem [DEPTH];
    entry_t          wr_entry;
    entry_t          head;

    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [PTCW-1:0] exp_ptcid_q, exp_ptcid_d;
    logic            err_q, err_d;

    logic            full, empty, push, pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = valid_in & ready_out;
    assign pop   = wb_valid;

    // Pack incoming results; an excepting instruction must not write any state.
    always_comb begin
        wr_entry.data    = {res_data4, res_data3, res_data2, res_data1};
        wr_entry.addr    = {res_addr4, res_addr3, res_addr2, res_addr1};
        wr_entry.segdata = {res_segdata4, res_segdata3, res_segdata2, res_segdata1};
        wr_entry.segaddr = {res_segaddr4, res_segaddr3, res_segaddr2, res_segaddr1};
        wr_entry.regld   = res_ie ? 4'b0000 : res_regld;
        wr_entry.segld   = res_ie ? 4'b0000 : res_segld;
        wr_entry.opsize  = res_opsize;
        wr_entry.ptcid   = res_ptcid;
        wr_entry.ie      = res_ie;
    end

    // Entry write; harmless during flush/reset since the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    // Next-state for pointers, occupancy, expected PTC id and order flag.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        exp_ptcid_d = exp_ptcid_q;
        err_d       = err_q;
        if (wb_valid && (head.ptcid != exp_ptcid_q)) begin
            err_d = 1'b1;
        end
        if (flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            exp_ptcid_d = flush_ptcid;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + AW'(1);
                exp_ptcid_d = exp_ptcid_q + PTCW'(1);
            end
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!clr) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            exp_ptcid_q <= '0;
            err_q       <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            exp_ptcid_q <= exp_ptcid_d;
            err_q       <= err_d;
        end
    end

    // Head entry drives the writeback bus; load enables gated by retire.
    always_comb begin
        head          = mem[rd_ptr_q];
        ready_out     = ~full;
        wb_valid      = ~empty & ~wb_hold;
        wb_data1      = head.data[0];
        wb_data2      = head.data[1];
        wb_data3      = head.data[2];
        wb_data4      = head.data[3];
        wb_addr1      = head.addr[0];
        wb_addr2      = head.addr[1];
        wb_addr3      = head.addr[2];
        wb_addr4      = head.addr[3];
        wb_segdata1   = head.segdata[0];
        wb_segdata2   = head.segdata[1];
        wb_segdata3   = head.segdata[2];
        wb_segdata4   = head.segdata[3];
        wb_segaddr1   = head.segaddr[0];
        wb_segaddr2   = head.segaddr[1];
        wb_segaddr3   = head.segaddr[2];
        wb_segaddr4   = head.segaddr[3];
        wb_opsize     = head.opsize;
        wb_inst_ptcid = head.ptcid;
        wb_regld      = head.regld & {4{wb_valid}};
        wb_segld      = head.segld & {4{wb_valid}};
        wb_exc        = wb_valid & head.ie;
        ptc_order_err = err_q;
        count         = count_q;
    end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Bench for wb_retire_queue: hand-written cycle table for the directed
// corner cases, then streaming and random traffic against a queue model.
module tb_wb_retire_queue;

    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [3:0][63:0] d;
        logic [3:0][2:0]  a;
        logic [3:0][15:0] sd;
        logic [3:0][2:0]  sa;
        logic [3:0]       rl;
        logic [3:0]       sl;
        logic [1:0]       os;
        logic [6:0]       ptc;
        logic             ie;
    } ent_t;

    typedef struct {
        logic       clr, vin;
        logic [6:0] ptc;
        logic       ie;
        logic [3:0] rl, sl;
        logic       hold, fl;
        logic [6:0] fptc;
        logic       ev;
        logic [3:0] erl, esl;
        logic       eexc, erdy;
        int         ecnt;
        logic       eerr;
        logic [6:0] eptc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr, valid_in, ready_out, wb_hold, flush;
    logic [6:0]  flush_ptcid;
    ent_t        in_e;
    logic [63:0] wb_data1, wb_data2, wb_data3, wb_data4;
    logic [2:0]  wb_addr1, wb_addr2, wb_addr3, wb_addr4;
    logic [15:0] wb_segdata1, wb_segdata2, wb_segdata3, wb_segdata4;
    logic [2:0]  wb_segaddr1, wb_segaddr2, wb_segaddr3, wb_segaddr4;
    logic [1:0]  wb_opsize;
    logic [6:0]  wb_inst_ptcid;
    logic [3:0]  wb_regld, wb_segld;
    logic        wb_valid, wb_exc, ptc_order_err;
    logic [1:0]  count;

    wb_retire_queue #(.DEPTH(DEPTH), .PTCW(7)) dut (
        .clk(clk), .clr(clr), .valid_in(valid_in), .ready_out(ready_out),
        .res_data1(in_e.d[0]), .res_data2(in_e.d[1]), .res_data3(in_e.d[2]),
        .res_data4(in_e.d[3]),
        .res_addr1(in_e.a[0]), .res_addr2(in_e.a[1]), .res_addr3(in_e.a[2]),
        .res_addr4(in_e.a[3]), .res_regld(in_e.rl),
        .res_segdata1(in_e.sd[0]), .res_segdata2(in_e.sd[1]), .res_segdata3(in_e.sd[2]),
        .res_segdata4(in_e.sd[3]),
        .res_segaddr1(in_e.sa[0]), .res_segaddr2(in_e.sa[1]), .res_segaddr3(in_e.sa[2]),
        .res_segaddr4(in_e.sa[3]), .res_segld(in_e.sl),
        .res_opsize(in_e.os), .res_ptcid(in_e.ptc), .res_ie(in_e.ie),
        .wb_hold(wb_hold), .flush(flush), .flush_ptcid(flush_ptcid),
        .wb_data1(wb_data1), .wb_data2(wb_data2), .wb_data3(wb_data3), .wb_data4(wb_data4),
        .wb_addr1(wb_addr1), .wb_addr2(wb_addr2), .wb_addr3(wb_addr3), .wb_addr4(wb_addr4),
        .wb_segdata1(wb_segdata1), .wb_segdata2(wb_segdata2), .wb_segdata3(wb_segdata3),
        .wb_segdata4(wb_segdata4),
        .wb_segaddr1(wb_segaddr1), .wb_segaddr2(wb_segaddr2), .wb_segaddr3(wb_segaddr3),
        .wb_segaddr4(wb_segaddr4),
        .wb_opsize(wb_opsize), .wb_inst_ptcid(wb_inst_ptcid),
        .wb_regld(wb_regld), .wb_segld(wb_segld), .wb_valid(wb_valid), .wb_exc(wb_exc),
        .ptc_order_err(ptc_order_err), .count(count)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [63:0] tdata(input logic [6:0] p);
        return 64'hDEAD ^ {57'd0, p};
    endfunction

    function automatic logic [2:0] taddr(input logic [6:0] p);
        return p[2:0] ^ 3'd3;
    endfunction

    function automatic vec_t mk(input logic c, v, input logic [6:0] p, input logic ie,
                                input logic [3:0] rl, sl, input logic h, f,
                                input logic [6:0] fp, input logic ev,
                                input logic [3:0] erl, esl, input logic eexc, erdy,
                                input int ecnt, input logic eerr, input logic [6:0] eptc);
        vec_t t;
        t.clr = c; t.vin = v; t.ptc = p; t.ie = ie; t.rl = rl; t.sl = sl; t.hold = h;
        t.fl = f; t.fptc = fp; t.ev = ev; t.erl = erl; t.esl = esl; t.eexc = eexc;
        t.erdy = erdy; t.ecnt = ecnt; t.eerr = eerr; t.eptc = eptc;
        return t;
    endfunction

    function automatic ent_t rnd_ent(input logic [6:0] p);
        ent_t e;
        for (int i = 0; i < 4; i++) begin
            e.d[i]  = {$urandom, $urandom};
            e.a[i]  = 3'($urandom);
            e.sd[i] = 16'($urandom);
            e.sa[i] = 3'($urandom);
        end
        e.rl  = 4'($urandom);
        e.sl  = 4'($urandom);
        e.os  = 2'($urandom);
        e.ptc = p;
        e.ie  = ($urandom_range(9) == 0);
        return e;
    endfunction

    // Reference model: in-order list of buffered entries plus order state.
    ent_t       mq[$];
    logic [6:0] m_exp;
    logic       m_err;

    task automatic cyc(input logic c, v, input ent_t e, input logic h, f,
                       input logic [6:0] fp, output logic acc);
        logic mv, rdy;
        ent_t s;
        @(negedge clk);
        clr = c; valid_in = v; in_e = e; wb_hold = h; flush = f; flush_ptcid = fp;
        #1;
        mv  = (mq.size() > 0) && !h;
        rdy = (mq.size() < DEPTH);
        chk("ready", 384'(ready_out), 384'(rdy));
        chk("count", 384'(count), 384'(mq.size()));
        chk("wb_valid", 384'(wb_valid), 384'(mv));
        chk("order_err", 384'(ptc_order_err), 384'(m_err));
        if (mq.size() > 0) begin
            chk("wb_exc", 384'(wb_exc), 384'(mv & mq[0].ie));
            chk("wb_regld", 384'(wb_regld), 384'(mv ? mq[0].rl : 4'd0));
            chk("wb_segld", 384'(wb_segld), 384'(mv ? mq[0].sl : 4'd0));
            chk("head", 384'({wb_data4, wb_data3, wb_data2, wb_data1,
                              wb_addr4, wb_addr3, wb_addr2, wb_addr1,
                              wb_segdata4, wb_segdata3, wb_segdata2, wb_segdata1,
                              wb_segaddr4, wb_segaddr3, wb_segaddr2, wb_segaddr1,
                              wb_opsize, wb_inst_ptcid}),
                384'({mq[0].d, mq[0].a, mq[0].sd, mq[0].sa, mq[0].os, mq[0].ptc}));
        end else begin
            chk("idle_ld", 384'({wb_exc, wb_regld, wb_segld}), 384'(0));
        end
        @(posedge clk);
        acc = 1'b0;
        if (!c) begin
            mq.delete();
            m_exp = '0;
            m_err = 1'b0;
        end else begin
            if (mv && mq[0].ptc != m_exp) m_err = 1'b1;
            if (f) begin
                mq.delete();
                m_exp = fp;
            end else begin
                if (mv) begin
                    void'(mq.pop_front());
                    m_exp = m_exp + 7'd1;
                end
                if (v && rdy) begin
                    s = e;
                    if (s.ie) begin s.rl = '0; s.sl = '0; end
                    mq.push_back(s);
                    acc = 1'b1;
                end
            end
        end
    endtask

    vec_t       tab[28];
    ent_t       te;
    logic       acc;
    logic [6:0] nxt;

    initial begin
        tab[0]  = mk(0,0, 0,0,4'h0,4'h0,0,0, 0, 0,4'h0,4'h0,0,1,0,0, 0);
        tab[1]  = mk(1,1, 0,0,4'h1,4'h0,0,0, 0, 0,4'h0,4'h0,0,1,0,0, 0);
        tab[2]  = mk(1,0, 0,0,4'h0,4'h0,0,0, 0, 1,4'h1,4'h0,0,1,1,0, 0);
        tab[3]  = mk(1,0, 0,0,4'h0,4'h0,0,0, 0, 0,4'h0,4'h0,0,1,0,0, 0);
        tab[4]  = mk(0,0, 0,0,4'h0,4'h0,0,0, 0, 0,4'h0,4'h0,0,1,0,0, 0);
        tab[5]  = mk(1,1, 0,0,4'hf,4'h0,1,0, 0, 0,4'h0,4'h0,0,1,0,0, 0);
        tab[6]  = mk(1,1, 1,0,4'hf,4'h0,1,0, 0, 0,4'h0,4'h0,0,1,1,0, 0);
        tab[7]  = mk(1,1, 2,0,4'hf,4'h0,1,0, 0, 0,4'h0,4'h0,0,0,2,0, 0);
        tab[8]  = mk(1,1, 2,0,4'hf,4'h0,0,0, 0, 1,4'hf,4'h0,0,0,2,0, 0);
        tab[9]  = mk(1,1, 2,0,4'hf,4'h0,0,0, 0, 1,4'hf,4'h0,0,1,1,0, 1);
        tab[10] = mk(1,0, 0,0,4'h0,4'h0,0,0, 0, 1,4'hf,4'h0,0,1,1,0, 2);
        tab[11] = mk(1,0, 0,0,4'h0,4'h0,0,0, 0, 0,4'h0,4'h0,0,1,0,0, 0);
        tab[12] = mk(0,0, 0,0,4'h0,4'h0,0,0, 0, 0,4'h0,4'h0,0,1,0,0, 0);
        tab[13] = mk(1,1, 5,0,4'h2,4'h0,0,0, 0, 0,4'h0,4'h0,0,1,0,0, 0);
        tab[14] = mk(1,0, 0,0,4'h0,4'h0,0,0, 0, 1,4'h2,4'h0,0,1,1,0, 5);
        tab[15] = mk(1,0, 0,0,4'h0,4'h0,0,0, 0, 0,4'h0,4'h0,0,1,0,1, 0);
        tab[16] = mk(1,0, 0,0,4'h0,4'h0,0,0, 0, 0,4'h0,4'h0,0,1,0,1, 0);
        tab[17] = mk(0,0, 0,0,4'h0,4'h0,0,0, 0, 0,4'h0,4'h0,0,1,0,1, 0);
        tab[18] = mk(1,1, 0,1,4'hf,4'h2,0,0, 0, 0,4'h0,4'h0,0,1,0,0, 0);
        tab[19] = mk(1,0, 0,0,4'h0,4'h0,0,0, 0, 1,4'h0,4'h0,1,1,1,0, 0);
        tab[20] = mk(1,1, 1,0,4'h4,4'h1,0,0, 0, 0,4'h0,4'h0,0,1,0,0, 0);
        tab[21] = mk(1,0, 0,0,4'h0,4'h0,0,0, 0, 1,4'h4,4'h1,0,1,1,0, 1);
        tab[22] = mk(1,1, 2,0,4'h1,4'h0,1,0, 0, 0,4'h0,4'h0,0,1,0,0, 0);
        tab[23] = mk(1,1, 3,0,4'h1,4'h0,1,0, 0, 0,4'h0,4'h0,0,1,1,0, 0);
        tab[24] = mk(1,1, 9,0,4'h1,4'h0,1,1,40, 0,4'h0,4'h0,0,0,2,0, 0);
        tab[25] = mk(1,1,40,0,4'h1,4'h0,0,0, 0, 0,4'h0,4'h0,0,1,0,0, 0);
        tab[26] = mk(1,0, 0,0,4'h0,4'h0,0,0, 0, 1,4'h1,4'h0,0,1,1,0,40);
        tab[27] = mk(1,0, 0,0,4'h0,4'h0,0,0, 0, 0,4'h0,4'h0,0,1,0,0, 0);

        clr = 1'b0; valid_in = 1'b0; wb_hold = 1'b0; flush = 1'b0; flush_ptcid = '0;
        in_e = '0;
        repeat (2) @(posedge clk);

        // Directed cycle table: inputs applied at negedge, outputs checked 1ns later.
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            te = '0;
            te.ptc = tab[i].ptc; te.ie = tab[i].ie; te.rl = tab[i].rl; te.sl = tab[i].sl;
            te.d[0] = tdata(tab[i].ptc);
            te.a[0] = taddr(tab[i].ptc);
            clr = tab[i].clr; valid_in = tab[i].vin; in_e = te;
            wb_hold = tab[i].hold; flush = tab[i].fl; flush_ptcid = tab[i].fptc;
            #1;
            chk($sformatf("t%0d_valid", i), 384'(wb_valid), 384'(tab[i].ev));
            chk($sformatf("t%0d_regld", i), 384'(wb_regld), 384'(tab[i].erl));
            chk($sformatf("t%0d_segld", i), 384'(wb_segld), 384'(tab[i].esl));
            chk($sformatf("t%0d_exc", i), 384'(wb_exc), 384'(tab[i].eexc));
            chk($sformatf("t%0d_ready", i), 384'(ready_out), 384'(tab[i].erdy));
            chk($sformatf("t%0d_count", i), 384'(count), 384'(tab[i].ecnt));
            chk($sformatf("t%0d_err", i), 384'(ptc_order_err), 384'(tab[i].eerr));
            if (tab[i].ev) begin
                chk($sformatf("t%0d_ptcid", i), 384'(wb_inst_ptcid), 384'(tab[i].eptc));
                chk($sformatf("t%0d_data1", i), 384'(wb_data1), 384'(tdata(tab[i].eptc)));
                chk($sformatf("t%0d_addr1", i), 384'(wb_addr1), 384'(taddr(tab[i].eptc)));
            end
        end

        // Streaming: push and pop every cycle, ptcid wrapping through 127 -> 0.
        mq.delete(); m_exp = '0; m_err = 1'b0;
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, acc);
        for (int i = 0; i < 200; i++) begin
            te = rnd_ent(7'(i));
            te.ie = 1'b0;
            cyc(1'b1, 1'b1, te, 1'b0, 1'b0, '0, acc);
        end
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, acc);

        // Random traffic, mostly in-order ptcids with occasional faults.
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, acc);
        nxt = '0;
        for (int i = 0; i < 1500; i++) begin
            logic       c, v, h, f;
            logic [6:0] fp;
            c  = ($urandom_range(99) != 0);
            v  = ($urandom_range(99) < 60);
            h  = ($urandom_range(99) < 30);
            f  = ($urandom_range(99) < 3);
            fp = 7'($urandom);
            te = rnd_ent(($urandom_range(99) < 3) ? 7'($urandom) : nxt);
            cyc(c, v, te, h, f, fp, acc);
            if (!c) nxt = '0;
            else if (f) nxt = fp;
            else if (acc) nxt = te.ptc + 7'd1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
